// File: rtl/fsm_pkg.sv
// Shared constants for the input conditioner: pattern width,
// bit positions of i1..i4 and default timing parameters.
package fsm_pkg;

    localparam int PAT_W = 4;

    localparam int IDX_I1 = 0;
    localparam int IDX_I2 = 1;
    localparam int IDX_I3 = 2;
    localparam int IDX_I4 = 3;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Debounce counter width, enough for up to 255 cycles
    localparam int CNT_W = 8;

endpackage

// File: rtl/debounce_bit.sv
// One raw input: synchronizer chain, debounced stable level and
// a single-cycle pulse when a mismatch run dies before acceptance.
module debounce_bit
    import fsm_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic glitch_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s       = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    // Synchronizer shift chain plus debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count mismatch cycles; accept on the last one, flag a glitch on early return
    always_comb begin
        level_d  = level_q;
        cnt_d    = '0;
        glitch_o = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            glitch_o = (cnt_q != '0);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions four raw inputs into a registered pattern with a
// valid/ready handshake. INPUT_CONDITIONER_GLITCH_CNT_EN enables glitch_cnt.
module input_conditioner
    import fsm_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    input  logic             i4,
    output logic [PAT_W-1:0] pat,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             overrun,
    output logic [15:0]      glitch_cnt
);

    logic [PAT_W-1:0] raw;
    logic [PAT_W-1:0] level;
    logic [PAT_W-1:0] glitch;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    assign raw[IDX_I1] = i1;
    assign raw[IDX_I2] = i2;
    assign raw[IDX_I3] = i3;
    assign raw[IDX_I4] = i4;

    for (genvar g = 0; g < PAT_W; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw[g]),
            .level_o (level[g]),
            .glitch_o(glitch[g])
        );
    end

    assign pat       = pat_q;
    assign pat_valid = valid_q;
    assign overrun   = ovr_q;

    // Pattern register, pending flag and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A new debounced vector wins over a handshake on the same edge
    always_comb begin
        pat_d   = pat_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (level != pat_q) begin
            pat_d   = level;
            valid_d = 1'b1;
            if (valid_q && !pat_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && pat_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic [15:0] gcnt_q, gcnt_d;
    logic [2:0]  gsum;
    logic [16:0] gacc;

    // Saturating sum of this cycle's glitch pulses across all bits
    always_comb begin
        gsum = 3'(glitch[0]) + 3'(glitch[1])
             + 3'(glitch[2]) + 3'(glitch[3]);
        gacc = {1'b0, gcnt_q} + 17'(gsum);
        gcnt_d = gacc[16] ? 16'hFFFF : gacc[15:0];
    end

    // Glitch counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch;
    assign glitch_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: vector table plus
// hand-written corner sequences, with a pattern scoreboard.
`timescale 1ns/1ps
module tb_input_conditioner;

    typedef struct {
        logic [3:0] pat;
        int         due;
    } exp_t;

    typedef struct {
        logic [3:0] raw;
        logic       rdy;
        int         n;
        logic [3:0] pat;
        logic       vld;
        logic       ovr;
    } vec_t;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pat_ready = 1'b0;
    logic [3:0]  raw = 4'b0000;
    logic [3:0]  pat;
    logic        pat_valid;
    logic        overrun;
    logic [15:0] glitch_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [3:0]  last_pat = 4'b0000;
    vec_t        tv[12];

    input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i1        (raw[0]),
        .i2        (raw[1]),
        .i3        (raw[2]),
        .i4        (raw[3]),
        .pat       (pat),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .overrun   (overrun),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [3:0] r);
        if (r !== raw) sb.push_back('{r, cyc + 7});
        raw = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw = 4'b0000;
        pat_ready = 1'b0;
        sb.delete();
        wait_cyc(2);
        reset = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] p,
                           input logic v, input logic o);
        chk({nm, "_pat"}, 32'(pat), 32'(p));
        chk({nm, "_vld"}, 32'(pat_valid), 32'(v));
        chk({nm, "_ovr"}, 32'(overrun), 32'(o));
    endtask

    task automatic burst(input int n);
        for (int k = 0; k < n; k++) begin
            raw = 4'b1111;
            wait_cyc(1);
            raw = 4'b0000;
            wait_cyc(1);
        end
        wait_cyc(6);
    endtask

    // Scoreboard monitor: every pattern change must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_pat = 4'b0000;
        end else if (pat !== last_pat) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(pat), 32'(last_pat));
            end else begin
                e = sb.pop_front();
                chk("sb_pat", 32'(pat), 32'(e.pat));
                chk("sb_latency", 32'(cyc), 32'(e.due));
                chk("sb_valid", 32'(pat_valid), 32'd1);
            end
            last_pat = pat;
        end
    end

    initial begin
        tv[0]  = '{4'b0000, 1'b0, 2, 4'b0000, 1'b0, 1'b0};
        tv[1]  = '{4'b0100, 1'b0, 6, 4'b0000, 1'b0, 1'b0};
        tv[2]  = '{4'b0100, 1'b0, 1, 4'b0100, 1'b1, 1'b0};
        tv[3]  = '{4'b0100, 1'b0, 5, 4'b0100, 1'b1, 1'b0};
        tv[4]  = '{4'b0100, 1'b1, 1, 4'b0100, 1'b0, 1'b0};
        tv[5]  = '{4'b0100, 1'b1, 3, 4'b0100, 1'b0, 1'b0};
        tv[6]  = '{4'b0000, 1'b1, 7, 4'b0000, 1'b1, 1'b0};
        tv[7]  = '{4'b0000, 1'b1, 1, 4'b0000, 1'b0, 1'b0};
        tv[8]  = '{4'b0100, 1'b0, 7, 4'b0100, 1'b1, 1'b0};
        tv[9]  = '{4'b1101, 1'b0, 7, 4'b1101, 1'b1, 1'b1};
        tv[10] = '{4'b1101, 1'b1, 1, 4'b1101, 1'b0, 1'b1};
        tv[11] = '{4'b0000, 1'b1, 8, 4'b0000, 1'b0, 1'b1};

        #2;
        chk_out("rst_hold", 4'b0000, 1'b0, 1'b0);
        chk("rst_gcnt", 32'(glitch_cnt), 32'd0);
        do_reset();

        foreach (tv[i]) begin
            set_raw(tv[i].raw);
            pat_ready = tv[i].rdy;
            wait_cyc(tv[i].n);
            chk_out($sformatf("v%0d", i), tv[i].pat, tv[i].vld, tv[i].ovr);
        end

        // Handshake on the same edge as a new pattern load
        do_reset();
        set_raw(4'b0010);
        wait_cyc(7);
        chk_out("a_first", 4'b0010, 1'b1, 1'b0);
        set_raw(4'b0011);
        wait_cyc(6);
        pat_ready = 1'b1;
        wait_cyc(1);
        chk_out("a_coinc", 4'b0011, 1'b1, 1'b0);
        wait_cyc(1);
        chk_out("a_ack", 4'b0011, 1'b0, 1'b0);
        pat_ready = 1'b0;

        // Short i1 pulse must be rejected as a glitch
        do_reset();
        raw = 4'b0001;
        wait_cyc(3);
        raw = 4'b0000;
        wait_cyc(10);
        chk_out("b_glitch", 4'b0000, 1'b0, 1'b0);
        chk("b_gcnt", 32'(glitch_cnt), GC_EN ? 32'd1 : 32'd0);

        // Asynchronous reset mid-debounce with state pending
        do_reset();
        raw = 4'b0010;
        wait_cyc(3);
        raw = 4'b0000;
        wait_cyc(8);
        chk("c_gcnt", 32'(glitch_cnt), GC_EN ? 32'd1 : 32'd0);
        set_raw(4'b1000);
        wait_cyc(7);
        chk_out("c_p1", 4'b1000, 1'b1, 1'b0);
        set_raw(4'b1001);
        wait_cyc(7);
        chk_out("c_p2", 4'b1001, 1'b1, 1'b1);
        set_raw(4'b1011);
        wait_cyc(4);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk_out("c_async", 4'b0000, 1'b0, 1'b0);
        chk("c_async_gcnt", 32'(glitch_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back('{4'b1011, cyc + 7});
        wait_cyc(6);
        chk_out("c_early", 4'b0000, 1'b0, 1'b0);
        wait_cyc(1);
        chk_out("c_reacc", 4'b1011, 1'b1, 1'b0);

        // Glitch counter growth and saturation
        do_reset();
        burst(1000);
        chk("d_mid", 32'(glitch_cnt), GC_EN ? 32'd4000 : 32'd0);
        chk("d_pat", 32'(pat), 32'd0);
        if (GC_EN) begin
            burst(16500);
            chk("d_sat", 32'(glitch_cnt), 32'hFFFF);
            burst(10);
            chk("d_nowrap", 32'(glitch_cnt), 32'hFFFF);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
